sevenseg_bcd_display: RTL and testbench

//  Downstream consumer of the 8-bit LED counter value on Basys3. Samples an 8-bit

---
 rtl/sevenseg_bcd_display.sv | 205 ++++++++++++++++++++
 tb/tb_sevenseg_bcd_display.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_bcd_display.sv
// Purpose: binary-to-BCD (double-dabble) converter driving a 4-digit multiplexed 7-seg display.
// Latency: value sampled in IDLE at cycle T -> conv_done at T+9 -> display register valid at T+10.
// Backpressure: none; the converter free-runs and value changes outside IDLE wait for the next IDLE.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   value[7:0]          binary value to show; hex_mode / blank_lz are sampled with it
//   seg[6:0]            {g,f,e,d,c,b,a}, active-low, registered
//   dp                  decimal point, active-low, always off
//   an[3:0]             digit anodes, active-low, registered; an[0] is the rightmost digit
//   conv_done           one-cycle pulse while the new result is being latched for display
module sevenseg_bcd_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       hex_mode,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       conv_done
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // Converter state
  state_t      state_q,   state_d;
  logic [2:0]  cnt_q,     cnt_d;
  logic [7:0]  bin_q,     bin_d;
  logic [11:0] bcd_q,     bcd_d;
  logic [7:0]  cap_val_q, cap_val_d;
  logic        cap_hex_q, cap_hex_d;
  logic        cap_blz_q, cap_blz_d;

  // Display register: only ever written with a finished conversion
  logic [11:0] disp_q,     disp_d;
  logic        disp_hex_q, disp_hex_d;
  logic        disp_blz_q, disp_blz_d;

  // Scan state
  logic [CW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q,     idx_d;
  logic [6:0]    seg_q,     seg_d;
  logic [3:0]    an_q,      an_d;

  logic [11:0] adj;
  logic [3:0]  d0, d1, d2;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [6:0] font7(input logic [3:0] n);
    case (n)
      4'h0:    font7 = 7'b1000000;
      4'h1:    font7 = 7'b1111001;
      4'h2:    font7 = 7'b0100100;
      4'h3:    font7 = 7'b0110000;
      4'h4:    font7 = 7'b0011001;
      4'h5:    font7 = 7'b0010010;
      4'h6:    font7 = 7'b0000010;
      4'h7:    font7 = 7'b1111000;
      4'h8:    font7 = 7'b0000000;
      4'h9:    font7 = 7'b0010000;
      4'hA:    font7 = 7'b0001000;
      4'hB:    font7 = 7'b0000011;
      4'hC:    font7 = 7'b1000110;
      4'hD:    font7 = 7'b0100001;
      4'hE:    font7 = 7'b0000110;
      default: font7 = 7'b0001110;
    endcase
  endfunction

  // Converter FSM: next state and datapath
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cap_val_d  = cap_val_q;
    cap_hex_d  = cap_hex_q;
    cap_blz_d  = cap_blz_q;
    disp_d     = disp_q;
    disp_hex_d = disp_hex_q;
    disp_blz_d = disp_blz_q;
    conv_done  = 1'b0;

    // Add-3 correction on each BCD nibble before the shift.
    adj[3:0]   = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
    adj[7:4]   = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
    adj[11:8]  = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];

    case (state_q)
      S_IDLE: begin
        cap_val_d = value;
        cap_hex_d = hex_mode;
        cap_blz_d = blank_lz;
        bin_d     = value;
        bcd_d     = 12'h000;
        cnt_d     = 3'd0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        disp_d     = cap_hex_q ? {4'h0, cap_val_q} : bcd_q;
        disp_hex_d = cap_hex_q;
        disp_blz_d = cap_blz_q;
        conv_done  = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scan: refresh divider, digit index, and per-slot segment/anode decode
  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end

    d0    = disp_q[3:0];
    d1    = disp_q[7:4];
    d2    = disp_q[11:8];
    nib   = 4'h0;
    blank = 1'b0;

    case (idx_q)
      2'd0: begin
        nib = d0;
      end
      2'd1: begin
        nib = d1;
        // Decimal tens only blank when the hundreds digit is blank too.
        blank = disp_blz_q && (disp_hex_q ? (d1 == 4'h0) : ((d2 == 4'h0) && (d1 == 4'h0)));
      end
      2'd2: begin
        nib   = d2;
        blank = disp_hex_q || (disp_blz_q && (d2 == 4'h0));
      end
      default: begin
        blank = 1'b1;
      end
    endcase

    seg_d = blank ? 7'h7F : font7(nib);
    an_d  = blank ? 4'hF  : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      bin_q      <= 8'h00;
      bcd_q      <= 12'h000;
      cap_val_q  <= 8'h00;
      cap_hex_q  <= 1'b0;
      cap_blz_q  <= 1'b0;
      disp_q     <= 12'h000;
      disp_hex_q <= 1'b0;
      disp_blz_q <= 1'b0;
      ref_cnt_q  <= '0;
      idx_q      <= 2'd0;
      seg_q      <= 7'h7F;
      an_q       <= 4'hF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cap_val_q  <= cap_val_d;
      cap_hex_q  <= cap_hex_d;
      cap_blz_q  <= cap_blz_d;
      disp_q     <= disp_d;
      disp_hex_q <= disp_hex_d;
      disp_blz_q <= disp_blz_d;
      ref_cnt_q  <= ref_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_sevenseg_bcd_display.sv
// Purpose: directed self-checking bench for sevenseg_bcd_display with REFRESH_DIV=4.
// Latency: checks conv_done timing relative to reset release and display scan contents.
// Backpressure: none; the bench only drives value/mode inputs and reset.
module tb_sevenseg_bcd_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'h00;
  logic       hex_mode = 1'b0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       conv_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Scan observation results (one full 16-cycle scan period)
  int         lit_cnt [4];
  logic [6:0] seg_at  [4];
  int         blank_cnt;
  int         bad_cnt;

  typedef struct packed {
    logic [7:0]      v;
    logic            hex;
    logic            blz;
    logic [3:0][6:0] s;   // expected seg per idx, {idx3,idx2,idx1,idx0}; 7F = blank slot
  } vec_t;

  sevenseg_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .hex_mode  (hex_mode),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .conv_done (conv_done)
  );

  always #5 clk = ~clk;

  task automatic observe_scan();
    for (int i = 0; i < 4; i++) begin
      lit_cnt[i] = 0;
      seg_at[i]  = 7'h7F;
    end
    blank_cnt = 0;
    bad_cnt   = 0;
    repeat (16) begin
      @(negedge clk);
      case (an)
        4'b1110: begin lit_cnt[0]++; seg_at[0] = seg; end
        4'b1101: begin lit_cnt[1]++; seg_at[1] = seg; end
        4'b1011: begin lit_cnt[2]++; seg_at[2] = seg; end
        4'b0111: begin lit_cnt[3]++; seg_at[3] = seg; end
        4'b1111: if (seg === 7'h7F) blank_cnt++; else bad_cnt++;
        default: bad_cnt++;
      endcase
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      if (conv_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL reset_an: got %b want 1111", an); end
    n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp: got %b want 1", dp); end
    n_cmp++; if (conv_done !== 1'b0) begin n_bad++; $display("FAIL reset_conv_done: got %b want 0", conv_done); end
  endtask

  task automatic test_conv_timing();
    logic exp;
    rst_n = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      exp = (n == 9 || n == 19 || n == 29);
      n_cmp++;
      if (conv_done !== exp) begin
        n_bad++;
        $display("FAIL conv_timing cycle %0d: conv_done=%b want %b", n, conv_done, exp);
      end
    end
  endtask

  task automatic test_decimal();
    vec_t tbl [9];
    int   nblank;
    tbl = '{
      '{8'd255, 1'b0, 1'b0, {7'h7F, 7'b0100100, 7'b0010010, 7'b0010010}},
      '{8'd7,   1'b0, 1'b1, {7'h7F, 7'h7F,      7'h7F,      7'b1111000}},
      '{8'd7,   1'b0, 1'b0, {7'h7F, 7'b1000000, 7'b1000000, 7'b1111000}},
      '{8'd100, 1'b0, 1'b1, {7'h7F, 7'b1111001, 7'b1000000, 7'b1000000}},
      '{8'd40,  1'b0, 1'b1, {7'h7F, 7'h7F,      7'b0011001, 7'b1000000}},
      '{8'd0,   1'b0, 1'b1, {7'h7F, 7'h7F,      7'h7F,      7'b1000000}},
      '{8'd99,  1'b0, 1'b0, {7'h7F, 7'b1000000, 7'b0010000, 7'b0010000}},
      '{8'd138, 1'b0, 1'b0, {7'h7F, 7'b1111001, 7'b0110000, 7'b0000000}},
      '{8'd246, 1'b0, 1'b0, {7'h7F, 7'b0100100, 7'b0011001, 7'b0000010}}
    };
    foreach (tbl[k]) begin
      @(negedge clk);
      value = tbl[k].v; hex_mode = tbl[k].hex; blank_lz = tbl[k].blz;
      repeat (24) @(negedge clk);
      observe_scan();
      nblank = 0;
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (tbl[k].s[i] == 7'h7F) begin
          nblank++;
          if (lit_cnt[i] !== 0) begin
            n_bad++;
            $display("FAIL dec v=%0d idx%0d: lit %0d cycles seg=%b, want blank", tbl[k].v, i, lit_cnt[i], seg_at[i]);
          end
        end else if (lit_cnt[i] !== 4 || seg_at[i] !== tbl[k].s[i]) begin
          n_bad++;
          $display("FAIL dec v=%0d idx%0d: lit %0d cycles seg=%b, want 4 cycles seg=%b", tbl[k].v, i, lit_cnt[i], seg_at[i], tbl[k].s[i]);
        end
      end
      n_cmp++;
      if (blank_cnt !== 4 * nblank || bad_cnt !== 0) begin
        n_bad++;
        $display("FAIL dec v=%0d blanks: blank=%0d bad=%0d, want blank=%0d bad=0", tbl[k].v, blank_cnt, bad_cnt, 4 * nblank);
      end
    end
  endtask

  task automatic test_hex();
    vec_t tbl [5];
    int   nblank;
    tbl = '{
      '{8'hAF, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'b0001000, 7'b0001110}},
      '{8'h0A, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F,      7'b0001000}},
      '{8'h0A, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'b1000000, 7'b0001000}},
      '{8'hBC, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'b0000011, 7'b1000110}},
      '{8'hDE, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'b0100001, 7'b0000110}}
    };
    foreach (tbl[k]) begin
      @(negedge clk);
      value = tbl[k].v; hex_mode = tbl[k].hex; blank_lz = tbl[k].blz;
      repeat (24) @(negedge clk);
      observe_scan();
      nblank = 0;
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (tbl[k].s[i] == 7'h7F) begin
          nblank++;
          if (lit_cnt[i] !== 0) begin
            n_bad++;
            $display("FAIL hex v=%h idx%0d: lit %0d cycles seg=%b, want blank", tbl[k].v, i, lit_cnt[i], seg_at[i]);
          end
        end else if (lit_cnt[i] !== 4 || seg_at[i] !== tbl[k].s[i]) begin
          n_bad++;
          $display("FAIL hex v=%h idx%0d: lit %0d cycles seg=%b, want 4 cycles seg=%b", tbl[k].v, i, lit_cnt[i], seg_at[i], tbl[k].s[i]);
        end
      end
      n_cmp++;
      if (blank_cnt !== 4 * nblank || bad_cnt !== 0) begin
        n_bad++;
        $display("FAIL hex v=%h blanks: blank=%0d bad=%0d, want blank=%0d bad=0", tbl[k].v, blank_cnt, bad_cnt, 4 * nblank);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    bit   ok;
    logic exp;
    wait_done(30, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midrst_sync: conv_done=%b, want a pulse within 30 cycles", conv_done); end
    // From the DONE cycle: IDLE, SHIFT1, SHIFT2, SHIFT3, SHIFT4.
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL midrst_seg: got %b want 1111111", seg); end
    n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL midrst_an: got %b want 1111", an); end
    n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL midrst_dp: got %b want 1", dp); end
    n_cmp++; if (conv_done !== 1'b0) begin n_bad++; $display("FAIL midrst_conv_done: got %b want 0", conv_done); end
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      exp = (n == 9);
      n_cmp++;
      if (conv_done !== exp) begin
        n_bad++;
        $display("FAIL midrst_timing cycle %0d: conv_done=%b want %b", n, conv_done, exp);
      end
    end
  endtask

  task automatic test_value_change();
    bit         ok;
    int         pulses, early, bad, li;
    logic [6:0] e100 [4];
    logic [6:0] e42  [4];
    e100 = '{7'b1000000, 7'b1000000, 7'b1111001, 7'h7F};
    e42  = '{7'b0100100, 7'b0011001, 7'b1000000, 7'h7F};
    @(negedge clk);
    value = 8'd100; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (24) @(negedge clk);
    wait_done(30, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL chg_sync: conv_done=%b, want a pulse within 30 cycles", conv_done); end
    // DONE -> IDLE -> SHIFT1 -> SHIFT2: change the input mid-conversion.
    repeat (3) @(negedge clk);
    value = 8'd42;
    pulses = 0; early = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (conv_done === 1'b1) pulses++;
      case (an)
        4'b1110: li = 0;
        4'b1101: li = 1;
        4'b1011: li = 2;
        4'b0111: li = 3;
        default: li = -1;
      endcase
      if (li < 0) begin
        if (an !== 4'hF || seg !== 7'h7F) bad++;
      end else if (seg !== e100[li] && seg !== e42[li]) begin
        bad++;
      end else if (pulses < 2 && seg !== e100[li]) begin
        early++;
      end
    end
    n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL chg_pulses: got %0d want 4", pulses); end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL chg_early: new digits shown %0d cycles early, want 0", early); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL chg_intermediate: %0d unexpected patterns, want 0", bad); end
    observe_scan();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (lit_cnt[i] !== 4 || seg_at[i] !== e42[i]) begin
        n_bad++;
        $display("FAIL chg_final idx%0d: lit %0d cycles seg=%b, want 4 cycles seg=%b", i, lit_cnt[i], seg_at[i], e42[i]);
      end
    end
    n_cmp++;
    if (lit_cnt[3] !== 0 || blank_cnt !== 4 || bad_cnt !== 0) begin
      n_bad++;
      $display("FAIL chg_final idx3: lit=%0d blank=%0d bad=%0d, want 0/4/0", lit_cnt[3], blank_cnt, bad_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_conv_timing();
    test_decimal();
    test_hex();
    test_reset_mid_shift();
    test_value_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
